dense_layer1_mac: RTL and testbench

- Compute stage directly downstream of the layer-1 weight loader.
- Consumes the loader's flat weight bus once the loader's done is high, plus a flat input-activation vector.
- Computes OUT_SIZE dot products serially on one signed multiply-accumulator.
- Presents results as a flat accumulator-width bus with a one-cycle done pulse for the next layer.

---
 rtl/dense_pkg.sv | 25 ++
 rtl/mac_unit.sv | 43 ++++
 rtl/dense_layer1_mac.sv | 159 +++++++++++++++
 tb/tb_dense_layer1_mac.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared state encoding, accumulator sizing and flat-bus slice helpers
// for the layer-1 dense compute stage.
package dense_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Wide enough for IN_SIZE worst-case products of (-2^(W-1))^2.
  function automatic int acc_width(input int w, input int in_size);
    return 2 * w + $clog2(in_size) + 1;
  endfunction

  function automatic int w_lsb(input int j, input int i, input int in_size, input int w);
    return (j * in_size + i) * w;
  endfunction

  function automatic int y_lsb(input int j, input int acc_w);
    return j * acc_w;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed W x W multiplier feeding an ACC_W-wide accumulator with
// synchronous clear and enable.
module mac_unit #(
  parameter int W     = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*W-1:0]   prod_s;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // Full-precision product, sign-extended into the accumulator.
  always_comb begin
    prod_s = a * b;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-2*W){prod_s[2*W-1]}}, prod_s};
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dense_layer1_mac.sv
// Layer-1 dense compute stage: serial signed dot products on one MAC.
// Build option DENSE_RELU_EN clamps negative neuron sums to zero.
module dense_layer1_mac
  import dense_pkg::*;
#(
  parameter int IN_SIZE  = 3,
  parameter int OUT_SIZE = 2,
  parameter int W        = 8,
  parameter int ACC_W    = acc_width(W, IN_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         weights_valid,
  input  logic [IN_SIZE*OUT_SIZE*W-1:0] weights_in,
  input  logic [IN_SIZE*W-1:0]         x_in,
  output logic                         busy,
  output logic [OUT_SIZE*ACC_W-1:0]    y_out,
  output logic                         done
);

  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int JW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  state_e                          state_q, state_d;
  logic [IW-1:0]                   i_q, i_d;
  logic [JW-1:0]                   j_q, j_d;
  logic [IN_SIZE*OUT_SIZE*W-1:0]   w_q, w_d;
  logic [IN_SIZE*W-1:0]            x_q, x_d;
  logic [OUT_SIZE*ACC_W-1:0]       y_q, y_d;
  logic                            busy_q, done_q;
  logic                            mac_clr_s, mac_en_s, wr_en_s;
  logic signed [W-1:0]             a_s, b_s;
  logic signed [ACC_W-1:0]         mac_acc_s, wr_val_s;

  // Sequencing FSM, counters and operand latches.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    w_d       = w_q;
    x_d       = x_q;
    mac_clr_s = 1'b0;
    mac_en_s  = 1'b0;
    wr_en_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && weights_valid) begin
          w_d       = weights_in;
          x_d       = x_in;
          i_d       = '0;
          j_d       = '0;
          mac_clr_s = 1'b1;
          state_d   = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        mac_en_s = 1'b1;
        if (i_q == IW'(IN_SIZE - 1)) begin
          i_d     = '0;
          state_d = WRITE;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      WRITE: begin
        wr_en_s   = 1'b1;
        mac_clr_s = 1'b1;
        i_d       = '0;
        if (j_q == JW'(OUT_SIZE - 1)) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + JW'(1);
          state_d = MAC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand select from the latched weight and input vectors.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int j = 0; j < OUT_SIZE; j++) begin
      for (int i = 0; i < IN_SIZE; i++) begin
        a_s = (j_q == JW'(j) && i_q == IW'(i)) ? w_q[w_lsb(j, i, IN_SIZE, W) +: W] : a_s;
      end
    end
    for (int i = 0; i < IN_SIZE; i++) begin
      b_s = (i_q == IW'(i)) ? x_q[i*W +: W] : b_s;
    end
  end

  // Value stored into the current output slot.
  always_comb begin
`ifdef DENSE_RELU_EN
    wr_val_s = mac_acc_s[ACC_W-1] ? '0 : mac_acc_s;
`else
    wr_val_s = mac_acc_s;
`endif
  end

  // Output slot update during WRITE.
  always_comb begin
    y_d = y_q;
    for (int j = 0; j < OUT_SIZE; j++) begin
      if (wr_en_s && j_q == JW'(j)) begin
        y_d[y_lsb(j, ACC_W) +: ACC_W] = wr_val_s;
      end else begin
        y_d[y_lsb(j, ACC_W) +: ACC_W] = y_q[y_lsb(j, ACC_W) +: ACC_W];
      end
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      w_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      w_q     <= w_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= (state_d == MAC) || (state_d == WRITE);
      done_q  <= (state_d == DONE);
    end
  end

  mac_unit #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr_s),
    .en  (mac_en_s),
    .a   (a_s),
    .b   (b_s),
    .acc (mac_acc_s)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign y_out = y_q;

endmodule

// File: tb/tb_dense_layer1_mac.sv
// Directed self-checking bench for dense_layer1_mac (IN_SIZE=3, OUT_SIZE=2, W=8).
module tb_dense_layer1_mac;

  localparam int IN_SIZE  = 3;
  localparam int OUT_SIZE = 2;
  localparam int W        = 8;
  localparam int ACC_W    = 18;
`ifdef DENSE_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          start = 1'b0;
  logic                          weights_valid = 1'b0;
  logic [IN_SIZE*OUT_SIZE*W-1:0] weights_in = '0;
  logic [IN_SIZE*W-1:0]          x_in = '0;
  logic                          busy;
  logic [OUT_SIZE*ACC_W-1:0]     y_out;
  logic                          done;

  int n_cmp = 0;
  int n_err = 0;

  dense_layer1_mac #(
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE),
    .W        (W),
    .ACC_W    (ACC_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .weights_valid (weights_valid),
    .weights_in    (weights_in),
    .x_in          (x_in),
    .busy          (busy),
    .y_out         (y_out),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pack_w(input int a0, input int a1, input int a2,
                                         input int b0, input int b1, input int b2);
    return {8'(b2), 8'(b1), 8'(b0), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [23:0] pack_x(input int x0, input int x1, input int x2);
    return {8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic int y_slot(input int j);
    logic signed [ACC_W-1:0] s;
    s = (j == 0) ? y_out[ACC_W-1:0] : y_out[2*ACC_W-1:ACC_W];
    return int'(s);
  endfunction

  function automatic int relu(input int v);
    return (RELU && v < 0) ? 0 : v;
  endfunction

  // One start pulse, then watch 14 cycles for latency, busy length, single done, results.
  task automatic run_op(input string tag, input int e0, input int e1);
    int lat, bcnt, dcnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; dcnt = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = c;
      end
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, bcnt, 8);
    check({tag, "_done_count"}, dcnt, 1);
    check({tag, "_y0"}, y_slot(0), relu(e0));
    check({tag, "_y1"}, y_slot(1), relu(e1));
  endtask

  initial begin
    int bcnt, dcnt, lat, d1, d2, b_at10, b_at11;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_y0", y_slot(0), 0);
    check("reset_y1", y_slot(1), 0);
    rst = 1'b0;
    weights_valid = 1'b1;

    // 1. Basic
    weights_in = pack_w(1, 2, 3, -1, 0, 4);
    x_in = pack_x(5, 6, 7);
    run_op("basic", 38, 23);

    // 2. Negative result / ReLU
    weights_in = pack_w(1, 2, 3, -4, -4, -4);
    x_in = pack_x(1, 1, 1);
    run_op("negative", 6, -12);
    check("negative_raw_bits", int'(y_out[2*ACC_W-1:ACC_W]), RELU ? 0 : 32'h3FFF4);

    // 3. Extreme operands
    weights_in = pack_w(-128, -128, -128, -128, -128, -128);
    x_in = pack_x(-128, -128, -128);
    run_op("extreme_neg", 49152, 49152);
    weights_in = pack_w(127, 127, 127, 127, 127, 127);
    run_op("extreme_mixed", -48768, -48768);

    // 4a. start without weights_valid is ignored
    weights_valid = 1'b0;
    weights_in = pack_w(1, 1, 1, 1, 1, 1);
    x_in = pack_x(1, 1, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) dcnt++;
    end
    check("gate_busy", bcnt, 0);
    check("gate_done", dcnt, 0);
    check("gate_y0_held", y_slot(0), relu(-48768));

    // 4b. start during busy ignored; operands changed mid-run have no effect
    weights_valid = 1'b1;
    weights_in = pack_w(1, 2, 3, -1, 0, 4);
    x_in = pack_x(5, 6, 7);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; dcnt = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 3) begin
        start = 1'b1;
        x_in = pack_x(9, 9, 9);
        weights_in = pack_w(2, 2, 2, 2, 2, 2);
        weights_valid = 1'b0;
      end
      if (c == 7) start = 1'b0;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = c;
      end
    end
    check("busy_start_latency", lat, 9);
    check("busy_start_done_count", dcnt, 1);
    check("busy_start_y0", y_slot(0), 38);
    check("busy_start_y1", y_slot(1), 23);
    weights_valid = 1'b1;

    // 5. Reset mid-operation
    weights_in = pack_w(1, 2, 3, -4, -4, -4);
    x_in = pack_x(1, 1, 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_y0", y_slot(0), 0);
    check("midrst_y1", y_slot(1), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    weights_in = pack_w(1, 2, 3, -1, 0, 4);
    x_in = pack_x(5, 6, 7);
    run_op("after_rst", 38, 23);

    // 6. Back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    d1 = 0; d2 = 0; dcnt = 0; b_at10 = -1; b_at11 = -1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 2) x_in = pack_x(1, 1, 1);
      if (c == 10) b_at10 = int'(busy);
      if (c == 11) b_at11 = int'(busy);
      if (c == 12) start = 1'b0;
      if (done) begin
        dcnt++;
        if (d1 == 0) begin
          d1 = c;
          check("b2b_run1_y0", y_slot(0), 38);
          check("b2b_run1_y1", y_slot(1), 23);
        end else if (d2 == 0) begin
          d2 = c;
        end
      end
    end
    check("b2b_done1_cycle", d1, 9);
    check("b2b_idle_gap_busy", b_at10, 0);
    check("b2b_reaccept_busy", b_at11, 1);
    check("b2b_done2_cycle", d2, 19);
    check("b2b_done_count", dcnt, 2);
    check("b2b_run2_y0", y_slot(0), 6);
    check("b2b_run2_y1", y_slot(1), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
